// File: rtl/sd_dat_sync_fifo_if.sv
// Handshake/data bundle between the SD DAT FIFO and its producer/consumer logic.
// The master modport is the side that drives requests; slave is the FIFO itself.
interface sd_dat_sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  Flush_in;
  logic [DATA_WIDTH-1:0] Data_in;
  logic                  WriteEn_in;
  logic                  ReadEn_in;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  Full_out;
  logic                  Empty_out;
  logic                  AlmostFull_out;
  logic                  AlmostEmpty_out;
  logic [ADDR_WIDTH:0]   Level_out;
  logic                  WriteAck_out;
  logic                  Overflow_out;
  logic                  Underflow_out;

  modport master (
    output Flush_in, Data_in, WriteEn_in, ReadEn_in,
    input  Data_out, Full_out, Empty_out, AlmostFull_out, AlmostEmpty_out,
    input  Level_out, WriteAck_out, Overflow_out, Underflow_out
  );

  modport slave (
    input  Flush_in, Data_in, WriteEn_in, ReadEn_in,
    output Data_out, Full_out, Empty_out, AlmostFull_out, AlmostEmpty_out,
    output Level_out, WriteAck_out, Overflow_out, Underflow_out
  );
endinterface

// File: rtl/sd_dat_sync_fifo.sv
// Single-clock circular FIFO for SD DAT block data with level, thresholds, sticky error flags and flush.
// Define SD_DAT_FIFO_FWFT_EN for first-word-fall-through output; default is registered read, latency 1.
module sd_dat_sync_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input logic                Clk,
  input logic                Reset_n,
  sd_dat_sync_fifo_if.slave  fifo_if
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LV = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_TH_LV = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0]   AE_TH_LV = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1'b1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   level_r;
  logic [ADDR_WIDTH:0]   level_nxt_s;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  write_ack_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  rd_ok_s;
  logic                  wr_ok_s;

  assign full_s  = (level_r == DEPTH_LV);
  assign empty_s = (level_r == {(ADDR_WIDTH+1){1'b0}});

  // A full FIFO still takes a write when a read frees a slot on the same edge; flush masks both.
  assign rd_ok_s = fifo_if.ReadEn_in & ~empty_s & ~fifo_if.Flush_in;
  assign wr_ok_s = fifo_if.WriteEn_in & (~full_s | rd_ok_s) & ~fifo_if.Flush_in;

  // Next level: net change of one only when exactly one side moves.
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge Clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= fifo_if.Data_in;
    end
  end

  // Pointers, level, read register and sticky flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
      level_r     <= {(ADDR_WIDTH+1){1'b0}};
      dout_r      <= {DATA_WIDTH{1'b0}};
      write_ack_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (fifo_if.Flush_in) begin
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
      level_r     <= {(ADDR_WIDTH+1){1'b0}};
      write_ack_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      // In FWFT builds dout_r keeps the last popped word for display while empty.
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        dout_r   <= mem_r[rd_ptr_r];
      end
      level_r     <= level_nxt_s;
      write_ack_r <= wr_ok_s;
      if (fifo_if.WriteEn_in & ~wr_ok_s) begin
        overflow_r <= 1'b1;
      end
      if (fifo_if.ReadEn_in & empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

`ifdef SD_DAT_FIFO_FWFT_EN
  assign fifo_if.Data_out = empty_s ? dout_r : mem_r[rd_ptr_r];
`else
  assign fifo_if.Data_out = dout_r;
`endif

  assign fifo_if.Full_out        = full_s;
  assign fifo_if.Empty_out       = empty_s;
  assign fifo_if.AlmostFull_out  = (level_r >= AF_TH_LV);
  assign fifo_if.AlmostEmpty_out = (level_r <= AE_TH_LV);
  assign fifo_if.Level_out       = level_r;
  assign fifo_if.WriteAck_out    = write_ack_r;
  assign fifo_if.Overflow_out    = overflow_r;
  assign fifo_if.Underflow_out   = underflow_r;

endmodule

// File: tb/tb_sd_dat_sync_fifo.sv
// Scoreboard bench for sd_dat_sync_fifo (DEPTH 16, thresholds 12/2); handles both output modes.
module tb_sd_dat_sync_fifo;

`ifdef SD_DAT_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  sd_dat_sync_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) fif ();

  sd_dat_sync_fifo #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .ALMOST_FULL_TH(12), .ALMOST_EMPTY_TH(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .fifo_if(fif)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  int          m_lvl = 0;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  logic [31:0] m_last = 32'h0;

  // One clock of stimulus; the model predicts acceptance, then Data_out is checked against the scoreboard.
  task automatic do_cycle(input bit fl, input bit we, input bit re, input logic [31:0] din);
    bit rd_ok;
    bit wr_ok;
    logic [31:0] exp_dout;
    fif.Flush_in   = fl;
    fif.WriteEn_in = we;
    fif.ReadEn_in  = re;
    fif.Data_in    = din;
    rd_ok = !fl && re && (m_lvl > 0);
    wr_ok = !fl && we && ((m_lvl < 16) || rd_ok);
    @(posedge Clk);
    #1;
    if (fl) begin
      sb.delete();
      m_lvl = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (we && !wr_ok) m_ovf = 1'b1;
      if (re && (m_lvl == 0)) m_unf = 1'b1;
      if (rd_ok) m_last = sb.pop_front();
      if (wr_ok) sb.push_back(din);
      m_lvl = m_lvl + int'(wr_ok) - int'(rd_ok);
    end
    exp_dout = (FWFT && (sb.size() > 0)) ? sb[0] : m_last;
    checks++;
    if (fif.Data_out !== exp_dout) begin
      errors++;
      $display("FAIL data_out: got %h expected %h", fif.Data_out, exp_dout);
    end
    fif.Flush_in   = 1'b0;
    fif.WriteEn_in = 1'b0;
    fif.ReadEn_in  = 1'b0;
  endtask

  task automatic test_reset();
    fif.Flush_in = 1'b0; fif.WriteEn_in = 1'b0; fif.ReadEn_in = 1'b0; fif.Data_in = 32'h0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({fif.Level_out, fif.Empty_out, fif.Full_out, fif.AlmostEmpty_out, fif.AlmostFull_out,
         fif.WriteAck_out, fif.Overflow_out, fif.Underflow_out} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL reset_status: got lvl=%0d e=%b f=%b ae=%b af=%b ack=%b ov=%b un=%b expected lvl=0 e=1 f=0 ae=1 af=0 ack=0 ov=0 un=0",
               fif.Level_out, fif.Empty_out, fif.Full_out, fif.AlmostEmpty_out, fif.AlmostFull_out,
               fif.WriteAck_out, fif.Overflow_out, fif.Underflow_out);
    end
    checks++;
    if (fif.Data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00000000", fif.Data_out);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_fill();
    int acks = 0;
    for (int i = 1; i <= 16; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 32'(i));
      acks += int'(fif.WriteAck_out);
      checks++;
      if ((fif.Level_out !== 5'(m_lvl)) || (fif.AlmostFull_out !== (m_lvl >= 12)) ||
          (fif.AlmostEmpty_out !== (m_lvl <= 2))) begin
        errors++;
        $display("FAIL fill_level: got lvl=%0d af=%b ae=%b expected lvl=%0d af=%b ae=%b",
                 fif.Level_out, fif.AlmostFull_out, fif.AlmostEmpty_out, m_lvl, m_lvl >= 12, m_lvl <= 2);
      end
    end
    checks++;
    if (acks != 16) begin
      errors++;
      $display("FAIL fill_acks: got %0d expected 16", acks);
    end
    checks++;
    if ({fif.Full_out, fif.Empty_out, fif.Level_out} !== {1'b1, 1'b0, 5'd16}) begin
      errors++;
      $display("FAIL fill_full: got f=%b e=%b lvl=%0d expected f=1 e=0 lvl=16", fif.Full_out, fif.Empty_out, fif.Level_out);
    end
  endtask

  task automatic test_full_rw();
    do_cycle(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    checks++;
    if ({fif.Level_out, fif.Full_out, fif.WriteAck_out, fif.Overflow_out} !== {5'd16, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_rw: got lvl=%0d f=%b ack=%b ov=%b expected lvl=16 f=1 ack=1 ov=0",
               fif.Level_out, fif.Full_out, fif.WriteAck_out, fif.Overflow_out);
    end
  endtask

  task automatic test_overflow();
    do_cycle(1'b0, 1'b1, 1'b0, 32'h00000099);
    checks++;
    if ({fif.Level_out, fif.WriteAck_out, fif.Overflow_out} !== {5'd16, 1'b0, m_ovf}) begin
      errors++;
      $display("FAIL overflow_set: got lvl=%0d ack=%b ov=%b expected lvl=16 ack=0 ov=%b",
               fif.Level_out, fif.WriteAck_out, fif.Overflow_out, m_ovf);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (fif.Overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b expected 1", fif.Overflow_out);
    end
    // Drain; the scoreboard expects 2..16 then DEADBEEF.
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if ({fif.Data_out, fif.Empty_out, fif.Underflow_out} !== {32'hDEADBEEF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL drain_last: got data=%h e=%b un=%b expected data=deadbeef e=1 un=0",
               fif.Data_out, fif.Empty_out, fif.Underflow_out);
    end
  endtask

  task automatic test_stream();
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h1000 + 32'(i));
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b0, 1'b1, 1'b1, $urandom);
      checks++;
      if ((fif.Level_out !== 5'd8) || (fif.WriteAck_out !== 1'b1)) begin
        errors++;
        $display("FAIL stream_level: cycle %0d got lvl=%0d ack=%b expected lvl=8 ack=1", i, fif.Level_out, fif.WriteAck_out);
      end
    end
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_underflow_flush();
    do_cycle(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if ({fif.Underflow_out, fif.Empty_out, fif.Level_out} !== {m_unf, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL underflow_set: got un=%b e=%b lvl=%0d expected un=%b e=1 lvl=0",
               fif.Underflow_out, fif.Empty_out, fif.Level_out, m_unf);
    end
    // Empty with both enables: write lands, read is refused.
    do_cycle(1'b0, 1'b1, 1'b1, 32'h00000077);
    checks++;
    if ({fif.Level_out, fif.WriteAck_out, fif.Underflow_out} !== {5'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL empty_rw: got lvl=%0d ack=%b un=%b expected lvl=1 ack=1 un=1",
               fif.Level_out, fif.WriteAck_out, fif.Underflow_out);
    end
    do_cycle(1'b1, 1'b1, 1'b1, 32'h00000055);
    checks++;
    if ({fif.Underflow_out, fif.Level_out, fif.Empty_out, fif.WriteAck_out} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL flush: got un=%b lvl=%0d e=%b ack=%b expected un=0 lvl=0 e=1 ack=0",
               fif.Underflow_out, fif.Level_out, fif.Empty_out, fif.WriteAck_out);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h2000 + 32'(i));
    do_cycle(1'b0, 1'b0, 1'b1, 32'h0);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h3000);
    fif.WriteEn_in = 1'b1;
    fif.Data_in    = 32'h4000;
    #3;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({fif.Level_out, fif.Empty_out, fif.Full_out, fif.AlmostEmpty_out, fif.AlmostFull_out,
         fif.WriteAck_out, fif.Overflow_out, fif.Underflow_out, fif.Data_out} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: got lvl=%0d e=%b f=%b ae=%b af=%b ack=%b ov=%b un=%b data=%h expected all reset values",
               fif.Level_out, fif.Empty_out, fif.Full_out, fif.AlmostEmpty_out, fif.AlmostFull_out,
               fif.WriteAck_out, fif.Overflow_out, fif.Underflow_out, fif.Data_out);
    end
    fif.WriteEn_in = 1'b0;
    sb.delete();
    m_lvl = 0; m_ovf = 1'b0; m_unf = 1'b0; m_last = 32'h0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_fwft();
    do_cycle(1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
    checks++;
    if ({fif.Data_out, fif.Empty_out} !== {32'hA5A5A5A5, 1'b0}) begin
      errors++;
      $display("FAIL fwft_visible: got data=%h e=%b expected data=a5a5a5a5 e=0", fif.Data_out, fif.Empty_out);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_overflow();
    test_stream();
    test_underflow_flush();
    test_async_reset();
    if (FWFT) test_fwft();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_dat_sync_fifo.md
Name: sd_dat_sync_fifo

Overview:
Parametrised single-clock FIFO that buffers SD DAT-line block data between the serializer/deserializer and the host bus side.
- Adds features the earlier buffering had no equivalent of: true circular addressing, simultaneous read and write, occupancy level, programmable almost-full and almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush.
- Sits between the DAT physical-layer shifter and the DMA/register interface.

Parameters:
DATA_WIDTH, 32, width of a stored word in bits (>=1)
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH words (>=2)
ALMOST_FULL_TH, 12, AlmostFull_out asserted when level >= this value (1..DEPTH)
ALMOST_EMPTY_TH, 2, AlmostEmpty_out asserted when level <= this value (0..DEPTH-1)

Ports:
Clk  in  1  single clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
Flush_in  in  1  synchronous clear of contents and flags
Data_in  in  DATA_WIDTH  write data
WriteEn_in  in  1  write request
ReadEn_in  in  1  read request
Data_out  out  DATA_WIDTH  read data
Full_out  out  1  level == DEPTH
Empty_out  out  1  level == 0
AlmostFull_out  out  1  level >= ALMOST_FULL_TH
AlmostEmpty_out  out  1  level <= ALMOST_EMPTY_TH
Level_out  out  ADDR_WIDTH+1  current word count, 0..DEPTH
WriteAck_out  out  1  one-cycle pulse, previous-cycle write accepted
Overflow_out  out  1  sticky, write attempted while full and not accepted
Underflow_out  out  1  sticky, read attempted while empty

Behaviour:
- Reset (Reset_n low, asynchronous):
  - Write and read pointers, Level_out, Data_out, WriteAck_out, Overflow_out and Underflow_out all go to 0.
  - Empty_out=1, Full_out=0, AlmostEmpty_out=1, AlmostFull_out=(ALMOST_FULL_TH==0 ? 1 : 0).
  - Memory contents are not cleared.
- Status outputs (Full, Empty, AlmostFull, AlmostEmpty) are combinational decodes of the registered level.
- Read accept (rd_ok) = ReadEn_in & !Empty_out.
- Write accept (wr_ok) = WriteEn_in & (!Full_out | rd_ok). A write into a full FIFO succeeds when a read is accepted in the same cycle.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. wr_ok stores Data_in at wr_ptr and increments wr_ptr; rd_ok increments rd_ptr.
- Level update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Standard mode read latency 1: on rd_ok, Data_out <= mem[rd_ptr] at the same edge. Otherwise Data_out holds its value.
- Empty with simultaneous WriteEn_in and ReadEn_in: write accepted, read rejected, Underflow_out set.
- WriteAck_out <= wr_ok every cycle.
- Overflow_out set on WriteEn_in & !wr_ok. Underflow_out set on ReadEn_in & Empty_out. Both stay high until reset or flush.
- Flush_in:
  - Highest priority. In the same cycle, WriteEn_in and ReadEn_in are ignored.
  - Pointers and level go to 0; Overflow_out, Underflow_out and WriteAck_out are cleared.
  - Data_out is unchanged.
- No internal state machine. Behaviour is fully defined by pointers and level. X on enables is not permitted.

Optional Feature:
Macro: SD_DAT_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - Data_out = mem[rd_ptr] combinationally whenever !Empty_out.
  - ReadEn_in pops the displayed word; the next word appears after the same edge.
  - A word written into an empty FIFO becomes visible the cycle after the write, when Empty_out falls.
  - When empty, Data_out holds the last popped word; after reset, 0.
- Undefined: standard registered read with latency 1, as described above.

Test Plan:
- Reset then write 0x00000001..0x00000010 (16 words, ADDR_WIDTH=4) -> Level_out=16, Full_out=1, AlmostFull_out high from level 12, WriteAck_out pulses 16 times.
- 17th write while full, no read -> word dropped, Overflow_out=1 and sticky, Level_out stays 16.
- Full FIFO with WriteEn_in and ReadEn_in both high, Data_in=0xDEADBEEF -> Data_out=0x00000001 next cycle, Level_out stays 16, no overflow, 0xDEADBEEF read out last.
- Continuous 40 writes and reads at level ~8 -> pointers wrap twice, output sequence identical to input, Level_out constant.
- Read on empty -> Underflow_out=1, Data_out unchanged. Then Flush_in pulse -> Underflow_out=0, Level_out=0, Empty_out=1.
- Reset_n pulled low mid-burst at level 5 -> all outputs return to reset values asynchronously. With SD_DAT_FIFO_FWFT_EN: write 0xA5A5A5A5 into empty -> Data_out=0xA5A5A5A5 one cycle later without ReadEn_in.
